// File: rtl/prbs8_checker_if.sv
// Byte stream handshake into the PRBS8 checker.
// The source drives data/valid; the checker answers with ready.
interface prbs8_checker_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/prbs8_checker.sv
// PRBS8 stream checker: locks onto the x^8+x^6+x^5+x^4+1 style sequence
// next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}, flywheels while locked and
// keeps saturating error/bit-error/received statistics.
// Optional feature macro: PRBS_CHK_BITERR_EN enables bit_err_count; without
// it bit_err_count is tied to zero and no popcount logic exists.
module prbs8_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             aclk,
    input  logic             reset,
    prbs8_checker_if.slave   bus,
    input  logic             clr,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic [CNT_W-1:0] rx_count
);

    localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0]    LOSS_LAST = LW'(LOSS_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    function automatic logic [7:0] prbs_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    state_t          state, state_n;
    logic [7:0]      expected, expected_n;
    logic [MW-1:0]   match_cnt, match_n;
    logic [LW-1:0]   miss_cnt, miss_n;
    logic            ready_q;
    logic            lost_n;
    logic            accept;
    logic            is_match;
    logic            inc_rx;
    logic            inc_err;

    assign bus.ready = ready_q;
    assign accept    = bus.valid && ready_q;
    assign is_match  = (bus.data == expected);
    assign locked    = (state == ST_LOCKED);

    // State register, reference byte, run counters and handshake ready.
    always_ff @(posedge aclk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= ST_SEARCH;
            expected  <= 8'h01;
            match_cnt <= '0;
            miss_cnt  <= '0;
            ready_q   <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            expected  <= expected_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            ready_q   <= 1'b1;
            lock_lost <= lost_n;
        end
    end

    // Next-state logic: seed, verify the run, then flywheel while locked.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n    = state;
        expected_n = expected;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        lost_n     = 1'b0;
        inc_rx     = 1'b0;
        inc_err    = 1'b0;

        case (state)
            ST_SEARCH: begin
                // 0x00 is the lock-up value of the generator and cannot seed.
                if (accept && bus.data != 8'h00) begin
                    expected_n = prbs_next(bus.data);
                    match_n    = '0;
                    state_n    = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (accept) begin
                    expected_n = prbs_next(bus.data);
                    if (is_match) begin
                        if (match_cnt == LOCK_LAST) begin
                            match_n = '0;
                            miss_n  = '0;
                            state_n = ST_LOCKED;
                        end else begin
                            match_n = match_cnt + MW'(1);
                        end
                    end else begin
                        match_n = '0;
                        if (bus.data == 8'h00) begin
                            state_n = ST_SEARCH;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    // Flywheel: the reference advances whether or not the byte matched.
                    expected_n = prbs_next(expected);
                    inc_rx     = 1'b1;
                    if (is_match) begin
                        miss_n = '0;
                    end else begin
                        inc_err = 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            miss_n  = '0;
                            lost_n  = 1'b1;
                            state_n = ST_SEARCH;
                        end else begin
                            miss_n = miss_cnt + LW'(1);
                        end
                    end
                end
            end
            default: begin
                state_n = ST_SEARCH;
            end
        endcase
    end

    // Saturating byte counters; clr wins over a coincident increment.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rx_count  <= '0;
            err_count <= '0;
        end else if (clr) begin
            rx_count  <= '0;
            err_count <= '0;
        end else begin
            if (inc_rx && rx_count != CNT_MAX) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (inc_err && err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

`ifdef PRBS_CHK_BITERR_EN
    localparam int SW = CNT_W + 4;

    function automatic logic [3:0] popcount8(input logic [7:0] x);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, x[i]};
        end
        return n;
    endfunction

    logic [SW-1:0] bit_sum;

    assign bit_sum = SW'(bit_err_count) + SW'(popcount8(bus.data ^ expected));

    // Saturating bit-error accumulator; the wide sum detects overflow.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            bit_err_count <= '0;
        end else if (clr) begin
            bit_err_count <= '0;
        end else if (inc_err) begin
            bit_err_count <= (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
        end
    end
`else
    assign bit_err_count = '0;
`endif

endmodule
